// File: rtl/pipe_ctrl_pkg.sv
// Shared types and sizing constants for the pipeline control unit.
package pipe_ctrl_pkg;
    localparam int NREGS = 8;
    localparam int RW    = 3;

    typedef enum logic {
        RUN  = 1'b0,
        LMSM = 1'b1
    } state_t;
endpackage

// File: rtl/lowest_set_bit.sv
// Priority encoder: index of the lowest set bit of vec, plus a found flag.
module lowest_set_bit #(
    parameter int NREGS = pipe_ctrl_pkg::NREGS,
    parameter int RW    = pipe_ctrl_pkg::RW
) (
    input  logic [NREGS-1:0] vec,
    output logic [RW-1:0]    idx,
    output logic             found
);
    // Scanning downward lets the lowest set bit be the last (winning) write.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = NREGS - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx   = RW'(i);
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Freeze/flush/bubble generation for the 6-stage core and LM/SM micro-op sequencing in RR.
module pipe_hazard_ctrl #(
    parameter int NREGS = pipe_ctrl_pkg::NREGS,
    parameter int RW    = pipe_ctrl_pkg::RW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             br_taken,
    input  logic             ex_is_load,
    input  logic             ex_rd_wr,
    input  logic [RW-1:0]    ex_rd,
    input  logic [RW-1:0]    rr_rs1,
    input  logic [RW-1:0]    rr_rs2,
    input  logic             rr_uses_rs1,
    input  logic             rr_uses_rs2,
    input  logic             rr_is_lmsm,
    input  logic [NREGS-1:0] rr_lmsm_mask,
    output logic             pc_freeze,
    output logic             if_id_freeze,
    output logic             id_rr_freeze,
    output logic             if_id_flush,
    output logic             id_rr_flush,
    output logic             rr_ex_bubble,
    output logic             uop_valid,
    output logic [RW-1:0]    uop_reg,
    output logic [RW-1:0]    uop_idx,
    output logic             lmsm_busy
);
    import pipe_ctrl_pkg::*;

    localparam logic [NREGS-1:0] ONE = NREGS'(1);

    state_t            state, state_nxt;
    logic [NREGS-1:0]  rem_mask, rem_mask_nxt;
    logic [RW-1:0]     count, count_nxt;

    logic [NREGS-1:0]  enc_vec;
    logic [RW-1:0]     enc_idx;
    logic              enc_found;
    logic [NREGS-1:0]  post_mask;
    logic              load_use;
    logic              freeze;

    assign enc_vec   = (state == LMSM) ? rem_mask : rr_lmsm_mask;
    assign post_mask = enc_vec & ~(ONE << enc_idx);
    assign load_use  = ex_is_load & ex_rd_wr &
                       ((rr_uses_rs1 & (rr_rs1 == ex_rd)) | (rr_uses_rs2 & (rr_rs2 == ex_rd)));

    lowest_set_bit #(.NREGS(NREGS), .RW(RW)) u_lsb (
        .vec   (enc_vec),
        .idx   (enc_idx),
        .found (enc_found)
    );

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            rem_mask <= '0;
            count    <= '0;
        end else begin
            state    <= state_nxt;
            rem_mask <= rem_mask_nxt;
            count    <= count_nxt;
        end
    end

    // NOTE: every output and next-state term gets a default first so no latch is inferred.
    always_comb begin
        state_nxt    = state;
        rem_mask_nxt = rem_mask;
        count_nxt    = count;
        freeze       = 1'b0;
        if_id_flush  = 1'b0;
        id_rr_flush  = 1'b0;
        rr_ex_bubble = 1'b0;
        uop_valid    = 1'b0;
        uop_reg      = '0;
        uop_idx      = '0;
        lmsm_busy    = 1'b0;

        if (!rst) begin
            lmsm_busy = (state == LMSM);
            if (br_taken) begin
                // Anything in RR is younger than the branch, including a half-issued LM/SM.
                if_id_flush  = 1'b1;
                id_rr_flush  = 1'b1;
                state_nxt    = RUN;
                rem_mask_nxt = '0;
                count_nxt    = '0;
            end else if (state == RUN) begin
                if (load_use) begin
                    freeze       = 1'b1;
                    rr_ex_bubble = 1'b1;
                end else if (rr_is_lmsm) begin
                    if (enc_found) begin
                        uop_valid    = 1'b1;
                        uop_reg      = enc_idx;
                        rem_mask_nxt = post_mask;
                        count_nxt    = RW'(1);
                        if (post_mask != '0) begin
                            freeze    = 1'b1;
                            state_nxt = LMSM;
                        end
                    end else begin
                        rr_ex_bubble = 1'b1;
                    end
                end
            end else begin
                uop_valid    = enc_found;
                uop_reg      = enc_idx;
                uop_idx      = count;
                rem_mask_nxt = post_mask;
                if (post_mask != '0) begin
                    freeze    = 1'b1;
                    count_nxt = count + RW'(1);
                end else begin
                    state_nxt = RUN;
                    count_nxt = '0;
                end
            end
        end
    end

    assign pc_freeze    = freeze;
    assign if_id_freeze = freeze;
    assign id_rr_freeze = freeze;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios then random traffic vs a queue-based model.
module tb_pipe_hazard_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       br_taken, ex_is_load, ex_rd_wr;
    logic [2:0] ex_rd, rr_rs1, rr_rs2;
    logic       rr_uses_rs1, rr_uses_rs2, rr_is_lmsm;
    logic [7:0] rr_lmsm_mask;
    logic       pc_freeze, if_id_freeze, id_rr_freeze, if_id_flush, id_rr_flush;
    logic       rr_ex_bubble, uop_valid, lmsm_busy;
    logic [2:0] uop_reg, uop_idx;

    int checks = 0;
    int passed = 0;

    // Model state: registers still to be issued for the LM/SM in flight, and the next ordinal.
    int pend[$];
    int nidx = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.NREGS(8), .RW(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .br_taken     (br_taken),
        .ex_is_load   (ex_is_load),
        .ex_rd_wr     (ex_rd_wr),
        .ex_rd        (ex_rd),
        .rr_rs1       (rr_rs1),
        .rr_rs2       (rr_rs2),
        .rr_uses_rs1  (rr_uses_rs1),
        .rr_uses_rs2  (rr_uses_rs2),
        .rr_is_lmsm   (rr_is_lmsm),
        .rr_lmsm_mask (rr_lmsm_mask),
        .pc_freeze    (pc_freeze),
        .if_id_freeze (if_id_freeze),
        .id_rr_freeze (id_rr_freeze),
        .if_id_flush  (if_id_flush),
        .id_rr_flush  (id_rr_flush),
        .rr_ex_bubble (rr_ex_bubble),
        .uop_valid    (uop_valid),
        .uop_reg      (uop_reg),
        .uop_idx      (uop_idx),
        .lmsm_busy    (lmsm_busy)
    );

    task automatic idle();
        rst = 1'b0; br_taken = 1'b0; ex_is_load = 1'b0; ex_rd_wr = 1'b0;
        ex_rd = '0; rr_rs1 = '0; rr_rs2 = '0; rr_uses_rs1 = 1'b0; rr_uses_rs2 = 1'b0;
        rr_is_lmsm = 1'b0; rr_lmsm_mask = '0;
    endtask

    // One clock: predict outputs from the rules, compare at the falling edge, then advance the model.
    task automatic step(input string tag);
        logic       e_frz, e_fl, e_bub, e_uv, e_busy;
        logic [2:0] e_reg, e_idx;
        logic [13:0] exp_v, obs_v;
        int regs[$];
        e_frz = 0; e_fl = 0; e_bub = 0; e_uv = 0; e_busy = 0; e_reg = 0; e_idx = 0;
        @(negedge clk);
        if (rst) begin
            pend.delete();
            nidx = 0;
        end else if (br_taken) begin
            e_fl   = 1;
            e_busy = (pend.size() != 0);
            pend.delete();
            nidx = 0;
        end else if (pend.size() == 0) begin
            if (ex_is_load && ex_rd_wr &&
                ((rr_uses_rs1 && rr_rs1 == ex_rd) || (rr_uses_rs2 && rr_rs2 == ex_rd))) begin
                e_frz = 1;
                e_bub = 1;
            end else if (rr_is_lmsm) begin
                for (int i = 0; i < 8; i++) if (rr_lmsm_mask[i]) regs.push_back(i);
                if (regs.size() == 0) begin
                    e_bub = 1;
                end else begin
                    e_uv  = 1;
                    e_reg = 3'(regs.pop_front());
                    e_idx = 0;
                    pend  = regs;
                    nidx  = 1;
                    e_frz = (pend.size() != 0);
                end
            end
        end else begin
            e_busy = 1;
            e_uv   = 1;
            e_reg  = 3'(pend.pop_front());
            e_idx  = 3'(nidx);
            nidx++;
            e_frz  = (pend.size() != 0);
        end
        exp_v = {e_frz, e_frz, e_frz, e_fl, e_fl, e_bub, e_uv, e_reg, e_idx, e_busy};
        obs_v = {pc_freeze, if_id_freeze, id_rr_freeze, if_id_flush, id_rr_flush,
                 rr_ex_bubble, uop_valid, uop_reg, uop_idx, lmsm_busy};
        checks++;
        assert (obs_v === exp_v) passed++;
        else $error("FAIL %s: got frz3/fl2/bub/uv/reg/idx/busy=%b expected %b", tag, obs_v, exp_v);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        rst = 1'b1;
        step("reset0");
        step("reset1");
        rst = 1'b0;
        step("idle");

        // Load-use on rs1, then EX holds a non-load.
        ex_is_load = 1; ex_rd_wr = 1; ex_rd = 3; rr_rs1 = 3; rr_uses_rs1 = 1;
        step("loaduse_stall");
        ex_is_load = 0;
        step("loaduse_release");
        idle();

        // LM with four registers, RR held while frozen.
        rr_is_lmsm = 1; rr_lmsm_mask = 8'b1010_0101;
        for (int i = 0; i < 4; i++) step($sformatf("lm_a5_%0d", i));
        idle();
        step("lm_a5_after");

        rr_is_lmsm = 1; rr_lmsm_mask = 8'b1000_0000;
        step("lm_single");
        rr_lmsm_mask = 8'h00;
        step("lm_empty");
        idle();
        step("lm_empty_after");

        // Branch on the second micro-op of a full mask.
        rr_is_lmsm = 1; rr_lmsm_mask = 8'hFF;
        step("br_abort_uop0");
        br_taken = 1;
        step("br_abort_flush");
        idle();
        step("br_abort_after");

        // Branch in the same cycle as an LM/SM start.
        br_taken = 1; rr_is_lmsm = 1; rr_lmsm_mask = 8'h0F;
        step("br_vs_start");
        idle();
        step("br_vs_start_after");

        // Load-use on the base register defers the start.
        ex_is_load = 1; ex_rd_wr = 1; ex_rd = 2; rr_rs1 = 2; rr_uses_rs1 = 1;
        rr_is_lmsm = 1; rr_lmsm_mask = 8'h03;
        step("prio_stall");
        ex_is_load = 0;
        step("prio_uop0");
        step("prio_uop1");
        idle();
        step("prio_after");

        // Reset in the middle of a sequence.
        rr_is_lmsm = 1; rr_lmsm_mask = 8'hFF;
        step("rst_mid_uop0");
        step("rst_mid_uop1");
        rst = 1;
        step("rst_mid_hold0");
        step("rst_mid_hold1");
        idle();
        step("rst_mid_after0");
        step("rst_mid_after1");

        for (int n = 0; n < 3000; n++) begin
            rst          = ($urandom_range(0, 99) == 0);
            br_taken     = ($urandom_range(0, 15) == 0);
            ex_is_load   = ($urandom_range(0, 2) == 0);
            ex_rd_wr     = ($urandom_range(0, 3) != 0);
            ex_rd        = 3'($urandom_range(0, 7));
            rr_rs1       = 3'($urandom_range(0, 7));
            rr_rs2       = 3'($urandom_range(0, 7));
            rr_uses_rs1  = $urandom_range(0, 1) == 1;
            rr_uses_rs2  = $urandom_range(0, 1) == 1;
            rr_is_lmsm   = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 3))
                0:       rr_lmsm_mask = 8'h00;
                1:       rr_lmsm_mask = 8'h01 << $urandom_range(0, 7);
                default: rr_lmsm_mask = 8'($urandom);
            endcase
            step($sformatf("rand_%0d", n));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline control unit for the 6-stage core (IF, ID, RR, EX, MEM, WB). It generates the freeze and flush controls for the PC, IF/ID and ID/RR pipeline registers, inserts load-use bubbles into RR/EX, and sequences multi-register load/store (LM/SM) instructions held in RR into one micro-op per cycle. It sits beside the RR stage, takes hazard information from RR and EX, and drives the existing freeze/br_taken inputs of the pipeline registers.

## Interface
Parameters:
- NREGS, 8: register-file size and LM/SM mask width.
- RW, 3: register index width; must equal clog2(NREGS).

Ports (clock and reset first):
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- br_taken  in  1  branch/jump resolved taken in EX.
- ex_is_load  in  1  instruction in EX is a load.
- ex_rd_wr  in  1  instruction in EX writes a register.
- ex_rd  in  RW  destination of the instruction in EX.
- rr_rs1, rr_rs2  in  RW  source registers of the instruction in RR.
- rr_uses_rs1, rr_uses_rs2  in  1  source-valid flags.
- rr_is_lmsm  in  1  instruction in RR is LM or SM.
- rr_lmsm_mask  in  NREGS  register list of the LM/SM in RR.
- pc_freeze, if_id_freeze, id_rr_freeze  out  1  hold the corresponding register.
- if_id_flush, id_rr_flush  out  1  kill write enables entering IF/ID and ID/RR.
- rr_ex_bubble  out  1  RR/EX captures a NOP (write enables 0).
- uop_valid  out  1  RR/EX takes the micro-op fields below instead of the RR instruction.
- uop_reg  out  RW  register for the current LM/SM micro-op.
- uop_idx  out  RW  micro-op ordinal; the address offset is uop_idx words.
- lmsm_busy  out  1  FSM is in state LMSM.

## Operation
- FSM states are RUN and LMSM. Registered state: remaining mask (NREGS), issue count (RW).
- Priority, highest first: rst, then br_taken, then load-use, then LM/SM.
- **br_taken, any state:**
  - Assert if_id_flush and id_rr_flush.
  - Freezes are 0 and uop_valid is 0.
  - Next state is RUN; mask and count are cleared. An in-progress LM/SM is aborted because it is younger than the branch.
- **Load-use, RUN:** the condition is ex_is_load & ex_rd_wr & ((rr_uses_rs1 & rr_rs1==ex_rd) | (rr_uses_rs2 & rr_rs2==ex_rd)).
  - Assert pc_freeze, if_id_freeze, id_rr_freeze and rr_ex_bubble for that cycle.
  - LM/SM start is deferred while this holds.
- **LM/SM start, RUN:** rr_is_lmsm with a nonzero mask and no hazard.
  - Emit a micro-op this cycle: uop_valid=1, uop_reg = lowest set bit of rr_lmsm_mask, uop_idx=0.
  - Register the remaining mask with that bit cleared, and count=1.
  - If the remaining mask ≠ 0: assert all three freezes and go to LMSM.
  - Else: no freeze and stay in RUN.
- **LM/SM with mask = 0:** treated as a NOP. Assert rr_ex_bubble, no freeze, no micro-op.
- **LMSM state:** each cycle emits uop_reg = lowest set bit of the remaining mask and uop_idx = count, then clears that bit and increments count.
  - Freezes are asserted while the post-clear mask ≠ 0.
  - On the last micro-op, freezes deassert and the next state is RUN, so ID/RR advances in the same cycle that RR/EX takes the last micro-op.
- Load-use is not evaluated in LMSM. Forwarding covers the base register, which was checked at start.
- Issue order is always ascending register index. The count never wraps, because at most NREGS micro-ops are issued.

## Timing
- All outputs are combinational from registered state and current inputs. This gives zero-cycle latency to the pipeline registers' next edge.
- All outputs are forced to 0 while rst=1. On the first edge with rst=1: state=RUN, mask=0, count=0.
- Load-use stall: exactly 1 cycle.
- LM/SM with k set bits: k cycles of uop_valid. Freezes are asserted for k-1 cycles. lmsm_busy is asserted for k-1 cycles, starting the cycle after start.
- br_taken in the same cycle as an LM/SM start: the flush wins; no micro-op and no state change away from RUN.
- rst in the middle of LMSM returns to RUN on the next edge; no further micro-ops are issued.

## Structure
- Shared package pipe_ctrl_pkg holds:
  - the state enum (RUN, LMSM);
  - the NREGS/RW constants.
- One sub-module, lowest_set_bit: parameterised NREGS-bit priority encoder.
  - Outputs the index (RW bits) and a found flag.
  - Instantiated once, with its input muxed between rr_lmsm_mask (RUN) and the remaining mask (LMSM).

## Test plan
- **Load-use:** ex_is_load=1, ex_rd=3, rr_rs1=3, rr_uses_rs1=1 → one cycle of all freezes plus rr_ex_bubble; next cycle (EX now a non-load) all 0.
- **LM/SM sequence:** LM with mask 8'b1010_0101 → uop_reg 0,2,5,7 with uop_idx 0,1,2,3; freezes high for 3 cycles; lmsm_busy high for 3 cycles; RUN after.
- **Single-bit and empty masks:** mask 8'b1000_0000 → one micro-op (reg 7, idx 0), no freeze. Mask 0 → rr_ex_bubble for 1 cycle, no uop_valid.
- **Branch abort:** br_taken asserted on the 2nd micro-op of mask 8'hFF → that cycle both flushes are asserted, uop_valid=0, freezes=0; next cycle state=RUN and lmsm_busy=0.
- **Priority:** load-use on the LM base register in the same cycle as rr_is_lmsm (mask 8'h03) → 1 stall cycle, then micro-ops for reg 0 then reg 1.
- **Reset mid-LMSM:** rst asserted during LMSM → all outputs 0 while rst=1; after release, state=RUN and no leftover micro-ops are issued.
